// File: rtl/three_phase_pwm_capture.sv
// Measures each phase's PWM high time over a 4*P carrier window and converts it back to a signed modulator estimate.
// Optional per-phase glitch filter after the synchronizers: define PWM_CAPTURE_GLITCH_FILTER_EN.
module three_phase_pwm_capture #(
  parameter int pwm_period_width = 16,
  parameter int sync_stages      = 2,
  parameter int filt_len         = 4
) (
  input  logic                               aclk,
  input  logic                               resetn,
  input  logic                               capture_en,
  input  logic signed [pwm_period_width-1:0] pwm_period,
  input  logic                               pwm_a_in,
  input  logic                               pwm_b_in,
  input  logic                               pwm_c_in,
  output logic signed [pwm_period_width-1:0] mod_a_est,
  output logic signed [pwm_period_width-1:0] mod_b_est,
  output logic signed [pwm_period_width-1:0] mod_c_est,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               overrun,
  input  logic                               overrun_clr
);
  localparam int W  = pwm_period_width;
  localparam int CW = W + 2;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  logic [2:0]             pin_raw;
  logic [2:0]             lvl;
  logic [sync_stages-1:0] sync_q [3];
  logic [sync_stages-1:0] sync_d [3];

  assign pin_raw = {pwm_c_in, pwm_b_in, pwm_a_in};

  // Bit 0 takes the raw pin; the MSB is the synchronized level.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    assign sync_d[gi] = {sync_q[gi][sync_stages-2:0], pin_raw[gi]};
    always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) sync_q[gi] <= '0;
      else         sync_q[gi] <= sync_d[gi];
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int             FCW       = $clog2(filt_len) + 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(filt_len - 1);

  logic [FCW-1:0] filt_cnt_q [3];
  logic [FCW-1:0] filt_cnt_d [3];
  logic           filt_lvl_q [3];
  logic           filt_lvl_d [3];

  // Counter tracks consecutive samples that disagree with the accepted level.
  for (genvar gi = 0; gi < 3; gi++) begin : g_filt
    logic sample;
    assign sample         = sync_q[gi][sync_stages-1];
    assign filt_cnt_d[gi] = (sample == filt_lvl_q[gi] || filt_cnt_q[gi] == FILT_LAST) ?
                            '0 : filt_cnt_q[gi] + FCW'(1);
    assign filt_lvl_d[gi] = (sample != filt_lvl_q[gi] && filt_cnt_q[gi] == FILT_LAST) ?
                            sample : filt_lvl_q[gi];
    assign lvl[gi]        = filt_lvl_q[gi];
    always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
        filt_cnt_q[gi] <= '0;
        filt_lvl_q[gi] <= 1'b0;
      end else begin
        filt_cnt_q[gi] <= filt_cnt_d[gi];
        filt_lvl_q[gi] <= filt_lvl_d[gi];
      end
    end
  end
`else
  for (genvar gi = 0; gi < 3; gi++) begin : g_nofilt
    assign lvl[gi] = sync_q[gi][sync_stages-1];
  end
`endif

  state_t              state_q, state_d;
  logic signed [W-1:0] pl_q, pl_d, pl_done_q, pl_done_d;
  logic [CW-1:0]       win_q, win_d, win_last;
  logic [CW-1:0]       hi_q [3];
  logic [CW-1:0]       hi_d [3];
  logic [CW-1:0]       hi_done_q [3];
  logic [CW-1:0]       hi_done_d [3];
  logic                pend_q, pend_d;
  logic                m_valid_q, m_valid_d;
  logic                overrun_q, overrun_d;
  logic signed [W-1:0] est_q [3];
  logic signed [W-1:0] est_d [3];
  logic signed [CW-1:0] pl_ext;
  logic                period_ok, load, drop;

  assign period_ok = !pwm_period[W-1] && (pwm_period != '0);
  assign win_last  = {pl_q, 2'b00} - CW'(1);

  always_comb begin
    state_d   = state_q;
    pl_d      = pl_q;
    win_d     = win_q;
    pl_done_d = pl_done_q;
    pend_d    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hi_d[i]      = hi_q[i];
      hi_done_d[i] = hi_done_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (capture_en && period_ok) begin
          state_d = ST_RUN;
          pl_d    = pwm_period;
          win_d   = '0;
          for (int i = 0; i < 3; i++) hi_d[i] = '0;
        end
      end
      ST_RUN: begin
        if (!capture_en) begin
          state_d = ST_IDLE;
          win_d   = '0;
          for (int i = 0; i < 3; i++) hi_d[i] = '0;
        end else if (win_q == win_last) begin
          // Close: freeze the totals including this cycle's sample, then restart with a fresh period.
          pend_d    = 1'b1;
          pl_done_d = pl_q;
          win_d     = '0;
          for (int i = 0; i < 3; i++) begin
            hi_done_d[i] = hi_q[i] + CW'(lvl[i]);
            hi_d[i]      = '0;
          end
          if (period_ok) pl_d = pwm_period;
          else           state_d = ST_IDLE;
        end else begin
          win_d = win_q + CW'(1);
          for (int i = 0; i < 3; i++) hi_d[i] = hi_q[i] + CW'(lvl[i]);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pl_ext = {{2{pl_done_q[W-1]}}, pl_done_q};
  assign load   = pend_q && (!m_valid_q || m_ready);
  assign drop   = pend_q && m_valid_q && !m_ready;

  for (genvar gi = 0; gi < 3; gi++) begin : g_conv
    logic signed [CW-1:0] diff, sat;
    assign diff      = $signed(hi_done_q[gi] >> 1) - pl_ext;
    assign sat       = (diff > pl_ext) ? pl_ext : (diff < -pl_ext) ? -pl_ext : diff;
    assign est_d[gi] = load ? W'(sat) : est_q[gi];
  end

  always_comb begin
    m_valid_d = m_valid_q;
    overrun_d = overrun_q;
    if (load)                        m_valid_d = 1'b1;
    else if (m_valid_q && m_ready)   m_valid_d = 1'b0;
    if (overrun_clr) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pl_q      <= '0;
      pl_done_q <= '0;
      win_q     <= '0;
      pend_q    <= 1'b0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        hi_q[i]      <= '0;
        hi_done_q[i] <= '0;
        est_q[i]     <= '0;
      end
    end else begin
      state_q   <= state_d;
      pl_q      <= pl_d;
      pl_done_q <= pl_done_d;
      win_q     <= win_d;
      pend_q    <= pend_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < 3; i++) begin
        hi_q[i]      <= hi_d[i];
        hi_done_q[i] <= hi_done_d[i];
        est_q[i]     <= est_d[i];
      end
    end
  end

  assign mod_a_est = est_q[0];
  assign mod_b_est = est_q[1];
  assign mod_c_est = est_q[2];
  assign m_valid   = m_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_three_phase_pwm_capture.sv
// Bench for three_phase_pwm_capture: periodic triangle-PWM pin patterns against an arithmetic high-time model.
module tb_three_phase_pwm_capture;
  localparam int W      = 16;
  localparam int SYNC   = 2;
  localparam int MAXLEN = 4 * 127;

  logic                aclk = 1'b0;
  logic                resetn = 1'b0;
  logic                capture_en = 1'b0;
  logic signed [W-1:0] pwm_period = 16'sd100;
  logic                pwm_a_in = 1'b0, pwm_b_in = 1'b0, pwm_c_in = 1'b0;
  logic signed [W-1:0] mod_a_est, mod_b_est, mod_c_est;
  logic                m_valid, overrun;
  logic                m_ready = 1'b1;
  logic                overrun_clr = 1'b0;

  always #5 aclk = ~aclk;

  three_phase_pwm_capture #(
    .pwm_period_width(W), .sync_stages(SYNC), .filt_len(4)
  ) dut (
    .aclk(aclk), .resetn(resetn), .capture_en(capture_en), .pwm_period(pwm_period),
    .pwm_a_in(pwm_a_in), .pwm_b_in(pwm_b_in), .pwm_c_in(pwm_c_in),
    .mod_a_est(mod_a_est), .mod_b_est(mod_b_est), .mod_c_est(mod_c_est),
    .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit pat [3][MAXLEN];
  int pat_len = 1;
  int tix = 0;
  int exp_est [3];

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Estimate from the number of high samples seen in one 4*P window.
  function automatic int model_est(input int cnt, input int p);
    int e;
    e = (cnt / 2) - p;
    if (e > p)  e = p;
    if (e < -p) e = -p;
    return e;
  endfunction

  // One carrier period of pin data; spikes replaces phase A with 2-cycle pulses every 20 cycles.
  task automatic set_pattern(input int p, input int ma, input int mb, input int mc, input bit spikes);
    int m, cnt, c;
    bit hi;
    pwm_period = W'(p);
    for (int ph = 0; ph < 3; ph++) begin
      m   = (ph == 0) ? ma : (ph == 1) ? mb : mc;
      cnt = 0;
      for (int t = 0; t < 4 * p; t++) begin
        c  = iabs(t - 2 * p) - p;
        hi = (m > c);
        if (ph == 0 && spikes) begin
          hi = ((t % 20) == 5) || ((t % 20) == 6);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
          if (hi) cnt++;
`endif
        end else if (hi) begin
          cnt++;
        end
        pat[ph][t] = hi;
      end
      exp_est[ph] = model_est(cnt, p);
    end
    pat_len = 4 * p;
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      tix      = (tix + 1) % pat_len;
      pwm_a_in = pat[0][tix];
      pwm_b_in = pat[1][tix];
      pwm_c_in = pat[2][tix];
    end
  end

  task automatic wait_valid(input int maxc, output int cyc);
    cyc = 0;
    while (cyc < maxc) begin
      @(negedge aclk);
      cyc++;
      if (m_valid) return;
    end
    check_val("timeout_m_valid", 0, 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic check_est(input string tag);
    check_val({tag, "_a"}, int'(mod_a_est), exp_est[0]);
    check_val({tag, "_b"}, int'(mod_b_est), exp_est[1]);
    check_val({tag, "_c"}, int'(mod_c_est), exp_est[2]);
  endtask

  task automatic settle(input int n_discard);
    int cyc;
    for (int k = 0; k < n_discard; k++) wait_valid(1200, cyc);
  endtask

  initial begin
    int cyc, p, lim, ma, mb, mc, rec_a, rec_b, rec_c;

    set_pattern(100, 50, 0, -50, 1'b0);
    capture_en = 1'b1;
    wait_cycles(3);
    check_val("reset_m_valid", int'(m_valid), 0);
    check_val("reset_overrun", int'(overrun), 0);
    check_val("reset_est_a", int'(mod_a_est), 0);
    resetn = 1'b1;

    // Nominal modulation, one result per 400-cycle window.
    settle(1);
    wait_valid(600, cyc);
    check_est("t1_w2");
    check_val("t1_tol_a", int'(iabs(int'(mod_a_est) - 50) <= 2), 1);
    check_val("t1_tol_b", int'(iabs(int'(mod_b_est)) <= 2), 1);
    check_val("t1_tol_c", int'(iabs(int'(mod_c_est) + 50) <= 2), 1);
    wait_valid(600, cyc);
    check_val("t1_interval", cyc, 400);
    check_est("t1_w3");
    wait_cycles(1);
    check_val("t1_pulse_low", int'(m_valid), 0);

    // Constant levels saturate to +/-P.
    set_pattern(100, 105, -105, 0, 1'b0);
    settle(2);
    wait_valid(600, cyc);
    check_est("t2_const");

    for (int k = 0; k < 8; k++) begin
      p   = int'($urandom_range(10, 60));
      lim = p - 4;
      ma  = int'($urandom_range(0, 2 * lim)) - lim;
      mb  = int'($urandom_range(0, 2 * lim)) - lim;
      mc  = int'($urandom_range(0, 2 * lim)) - lim;
      set_pattern(p, ma, mb, mc, 1'b0);
      settle(2);
      wait_valid(600, cyc);
      check_val($sformatf("rnd%0d_interval", k), cyc, 4 * p);
      check_est($sformatf("rnd%0d_p%0d", k, p));
    end

    // Short spikes on an otherwise low phase A.
    set_pattern(100, 0, 20, -30, 1'b1);
    settle(2);
    wait_valid(600, cyc);
    check_est("t6_spikes");

    // Period change mid-window only takes effect at the next boundary.
    set_pattern(100, 40, -10, 20, 1'b0);
    settle(2);
    wait_valid(600, cyc);
    wait_cycles(100);
    set_pattern(50, 20, -30, 10, 1'b0);
    wait_valid(600, cyc);
    check_val("t5_old_window", cyc + 100, 400);
    wait_valid(600, cyc);
    check_val("t5_new_window", cyc, 200);
    check_est("t5_p50");

    // Back-pressure: first result held, later ones dropped, overrun sticky.
    set_pattern(100, 60, 10, -70, 1'b0);
    settle(2);
    overrun_clr = 1'b1;
    wait_cycles(1);
    overrun_clr = 1'b0;
    m_ready = 1'b0;
    wait_valid(600, cyc);
    check_val("t3_first_no_overrun", int'(overrun), 0);
    check_est("t3_first");
    rec_a = int'(mod_a_est);
    rec_b = int'(mod_b_est);
    rec_c = int'(mod_c_est);
    set_pattern(100, -60, -10, 70, 1'b0);
    wait_cycles(404);
    check_val("t3_overrun_set", int'(overrun), 1);
    check_val("t3_valid_held", int'(m_valid), 1);
    check_val("t3_hold_a", int'(mod_a_est), rec_a);
    wait_cycles(400);
    check_val("t3_hold_b", int'(mod_b_est), rec_b);
    check_val("t3_hold_c", int'(mod_c_est), rec_c);
    capture_en = 1'b0;
    wait_cycles(3);
    m_ready     = 1'b1;
    overrun_clr = 1'b1;
    wait_cycles(1);
    overrun_clr = 1'b0;
    check_val("t3_valid_drop", int'(m_valid), 0);
    check_val("t3_overrun_clr", int'(overrun), 0);
    capture_en = 1'b1;

    // Asynchronous reset mid-window, then full-window latency after release.
    set_pattern(100, 30, -20, 70, 1'b0);
    m_ready = 1'b0;
    wait_valid(1200, cyc);
    wait_cycles(150);
    resetn = 1'b0;
    #1;
    check_val("t4_rst_m_valid", int'(m_valid), 0);
    check_val("t4_rst_est_a", int'(mod_a_est), 0);
    check_val("t4_rst_est_c", int'(mod_c_est), 0);
    @(negedge aclk);
    m_ready = 1'b1;
    resetn  = 1'b1;
    wait_valid(600, cyc);
    check_val("t4_latency_min", int'(cyc >= 4 * 100 + 1), 1);
    check_val("t4_latency_max", int'(cyc <= 4 * 100 + 1 + SYNC), 1);
    wait_valid(600, cyc);
    check_est("t4_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
